// File: rtl/active_list.sv
// active_list: in-order completion tracker (reorder buffer).
// Ports: alloc_* from rename, wb_* completions, br_* resolutions,
//   grad_* registered retirement output, count = live entries.
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

module active_list #(
    parameter int AL_SIZE = `AL_SIZE,
    parameter int IDX_W   = $clog2(AL_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    input  logic             alloc_uses_rd,
    input  logic [5:0]       alloc_rd,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_al_idx,
    input  logic             br_if_branch,
    input  logic             br_if_prediction_correct,
    input  logic [IDX_W-1:0] br_al_addr,
    output logic             grad_valid,
    output logic [IDX_W-1:0] grad_al_idx,
    output logic             grad_uses_rd,
    output logic [5:0]       grad_rd,
    output logic [IDX_W:0]   count
);

    logic [AL_SIZE-1:0] valid_q;
    logic [AL_SIZE-1:0] done_q;
    logic [AL_SIZE-1:0] uses_q;
    logic [5:0]         rd_q [AL_SIZE];

    logic [IDX_W:0]     head;
    logic [IDX_W:0]     tail;
    logic [IDX_W-1:0]   head_idx;
    logic [IDX_W-1:0]   tail_idx;
    logic [IDX_W-1:0]   br_off;
    logic [AL_SIZE-1:0] younger;

    logic full;
    logic mp;
    logic alloc_fire;
    logic wb_set;
    logic grad_fire;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign count    = tail - head;
    assign full     = (count == (IDX_W+1)'(AL_SIZE));

    assign mp = br_if_branch & ~br_if_prediction_correct
              & valid_q[br_al_addr];

    assign alloc_ready = ~full & ~mp;
    assign alloc_idx   = tail_idx;
    assign alloc_fire  = alloc_valid & alloc_ready;

    // Age is measured as distance from head; anything farther than
    // the branch is younger and gets squashed.
    assign br_off = br_al_addr - head_idx;

    for (genvar g = 0; g < AL_SIZE; g++) begin : g_age
        logic [IDX_W-1:0] off;
        assign off        = IDX_W'(g) - head_idx;
        assign younger[g] = (off > br_off);
    end

    // Squash beats a same-cycle writeback to a younger entry.
    assign wb_set = wb_valid & valid_q[wb_al_idx]
                  & ~(mp & younger[wb_al_idx]);

    assign grad_fire = valid_q[head_idx] & done_q[head_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            done_q       <= '0;
            uses_q       <= '0;
            head         <= '0;
            tail         <= '0;
            grad_valid   <= 1'b0;
            grad_al_idx  <= '0;
            grad_uses_rd <= 1'b0;
            grad_rd      <= '0;
            for (int i = 0; i < AL_SIZE; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            if (wb_set) begin
                done_q[wb_al_idx] <= 1'b1;
            end

            grad_valid <= grad_fire;
            if (grad_fire) begin
                valid_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
                head              <= head + 1'b1;
                grad_al_idx       <= head_idx;
                grad_uses_rd      <= uses_q[head_idx];
                grad_rd           <= rd_q[head_idx];
            end

            if (alloc_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                uses_q[tail_idx]  <= alloc_uses_rd;
                rd_q[tail_idx]    <= alloc_rd;
                tail              <= tail + 1'b1;
            end

            // Head is never younger than the branch, so graduation
            // and squash never touch the same entry.
            if (mp) begin
                tail <= head + {1'b0, br_off} + (IDX_W+1)'(1);
                for (int i = 0; i < AL_SIZE; i++) begin
                    if (younger[i]) begin
                        valid_q[i] <= 1'b0;
                        done_q[i]  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_active_list.sv
// tb_active_list: random stimulus vs queue-based reference model.
// Checks grad_*, count, alloc_ready, alloc_idx and reset values.
module tb_active_list;

    localparam int N = 32;
    localparam int W = 5;

    logic         clk;
    logic         rst_n;
    logic         alloc_valid;
    logic         alloc_uses_rd;
    logic [5:0]   alloc_rd;
    logic         alloc_ready;
    logic [W-1:0] alloc_idx;
    logic         wb_valid;
    logic [W-1:0] wb_al_idx;
    logic         br_if_branch;
    logic         br_if_prediction_correct;
    logic [W-1:0] br_al_addr;
    logic         grad_valid;
    logic [W-1:0] grad_al_idx;
    logic         grad_uses_rd;
    logic [5:0]   grad_rd;
    logic [W:0]   count;

    active_list #(.AL_SIZE(N)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .alloc_valid              (alloc_valid),
        .alloc_uses_rd            (alloc_uses_rd),
        .alloc_rd                 (alloc_rd),
        .alloc_ready              (alloc_ready),
        .alloc_idx                (alloc_idx),
        .wb_valid                 (wb_valid),
        .wb_al_idx                (wb_al_idx),
        .br_if_branch             (br_if_branch),
        .br_if_prediction_correct (br_if_prediction_correct),
        .br_al_addr               (br_al_addr),
        .grad_valid               (grad_valid),
        .grad_al_idx              (grad_al_idx),
        .grad_uses_rd             (grad_uses_rd),
        .grad_rd                  (grad_rd),
        .count                    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] rd;
        logic       uses;
        bit         done;
    } ent_t;

    ent_t q[$];
    int   head_abs;
    bit   eg_v;
    int   eg_idx;
    int   eg_rd;
    int   eg_uses;
    int   n_chk;
    int   n_bad;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int off_of(input int idx);
        return (idx - (head_abs % N) + N) % N;
    endfunction

    function automatic bit live(input int idx);
        return off_of(idx) < q.size();
    endfunction

    task automatic chk_reset();
        chk("rst_gv",  32'(grad_valid), 0);
        chk("rst_gi",  32'(grad_al_idx), 0);
        chk("rst_gu",  32'(grad_uses_rd), 0);
        chk("rst_gr",  32'(grad_rd), 0);
        chk("rst_cnt", 32'(count), 0);
        chk("rst_rdy", 32'(alloc_ready), 1);
        chk("rst_ai",  32'(alloc_idx), 0);
    endtask

    task automatic pick_idx(output logic [W-1:0] idx);
        if (q.size() > 0 && $urandom_range(0, 9) < 8)
            idx = W'((head_abs + $urandom_range(0, q.size() - 1)) % N);
        else
            idx = W'($urandom_range(0, N - 1));
    endtask

    initial begin
        int  pa, pw, pb, ob, ow, phase;
        bit  mp, g, rdy;
        n_chk = 0;
        n_bad = 0;
        head_abs = 0;
        eg_v = 0;
        rst_n = 1'b0;
        alloc_valid = 0; alloc_uses_rd = 0; alloc_rd = '0;
        wb_valid = 0; wb_al_idx = '0;
        br_if_branch = 0; br_if_prediction_correct = 0;
        br_al_addr = '0;
        @(negedge clk);
        #1 chk_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst_n = 1'b1;
            chk("grad_v", 32'(grad_valid), 32'(eg_v));
            if (eg_v) begin
                chk("grad_idx", 32'(grad_al_idx), 32'(eg_idx));
                chk("grad_rd",  32'(grad_rd), 32'(eg_rd));
                chk("grad_use", 32'(grad_uses_rd), 32'(eg_uses));
            end
            chk("count", 32'(count), 32'(q.size()));

            phase = (cyc / 150) % 4;
            case (phase)
                0: begin pa = 95; pw = 3;  pb = 2;  end
                1: begin pa = 5;  pw = 90; pb = 2;  end
                2: begin pa = 60; pw = 60; pb = 4;  end
                default: begin pa = 70; pw = 50; pb = 20; end
            endcase

            alloc_valid   = ($urandom_range(0, 99) < pa);
            alloc_uses_rd = 1'($urandom);
            alloc_rd      = 6'($urandom_range(0, 63));
            wb_valid      = ($urandom_range(0, 99) < pw);
            pick_idx(wb_al_idx);
            br_if_branch  = ($urandom_range(0, 99) < pb);
            br_if_prediction_correct = ($urandom_range(0, 2) == 0);
            pick_idx(br_al_addr);

            if (cyc == 2500) begin
                wb_valid = 1'b1;
                rst_n    = 1'b0;
            end
            #1;
            if (!rst_n) begin
                chk_reset();
                q.delete();
                head_abs = 0;
                eg_v = 0;
                continue;
            end

            mp  = br_if_branch && !br_if_prediction_correct
                  && live(int'(br_al_addr));
            ob  = off_of(int'(br_al_addr));
            rdy = (q.size() < N) && !mp;
            chk("ready", 32'(alloc_ready), 32'(rdy));
            chk("aidx",  32'(alloc_idx), 32'((head_abs + q.size()) % N));

            g = (q.size() > 0) && q[0].done;
            eg_v = g;
            if (g) begin
                eg_idx  = head_abs % N;
                eg_rd   = int'(q[0].rd);
                eg_uses = int'(q[0].uses);
            end
            if (wb_valid && live(int'(wb_al_idx))) begin
                ow = off_of(int'(wb_al_idx));
                if (!(mp && ow > ob)) q[ow].done = 1'b1;
            end
            if (mp) begin
                while (q.size() > ob + 1) void'(q.pop_back());
            end
            if (alloc_valid && rdy)
                q.push_back('{alloc_rd, alloc_uses_rd, 1'b0});
            if (g) begin
                void'(q.pop_front());
                head_abs++;
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
